// File: rtl/ccip_rd_requester.sv
// CCI-P c0 read requester: issues sequential cache-line reads, tracks in-flight requests, forwards returned lines.
// Optional watchdog (timeout_err port and cycle counter) is built when CCIP_RD_TIMEOUT_EN is defined.

module ccip_rd_requester #(
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [41:0]      base_addr,
    input  logic [CNT_W-1:0] num_lines,
    output logic             busy,
    output logic             done,
    output logic             tx_c0_valid,
    output logic [41:0]      tx_c0_addr,
    output logic [15:0]      tx_c0_mdata,
    input  logic             c0_tx_alm_full,
    input  logic             rx_c0_rsp_valid,
    input  logic [15:0]      rx_c0_mdata,
    input  logic [511:0]     rx_c0_data,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx,
    output logic [511:0]     out_data
`ifdef CCIP_RD_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int unsigned ADDR_W = 42;
    localparam int unsigned TAG_W  = 16;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;

    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 64 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("ccip_rd_requester: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    issued_q, issued_d;
    logic [CNT_W-1:0]    rcvd_q, rcvd_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic                busy_q, done_q, txv_q, ov_q;
    logic [ADDR_W-1:0]   txa_q;
    logic [TAG_W-1:0]    txm_q;
    logic [CNT_W-1:0]    oidx_q;
    logic [DATA_W-1:0]   odata_q;

    logic                issue_c;
    logic                rsp_acc_c;
    logic [ADDR_W-1:0]   issue_addr_c;
    logic [CNT_W-1:0]    issue_tag_c;

`ifdef CCIP_RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
    logic                to_hit_c;
`endif

    // Next-state, issue decision and response acceptance
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        issued_d     = issued_q;
        rcvd_d       = rcvd_q;
        issue_c      = 1'b0;
        issue_addr_c = base_q + ADDR_W'(issued_q);
        issue_tag_c  = issued_q;
        rsp_acc_c    = rx_c0_rsp_valid && (state_q != S_IDLE) && (outst_q != '0);
        if (rsp_acc_c) begin
            rcvd_d = rcvd_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    num_d    = num_lines;
                    issued_d = '0;
                    rcvd_d   = '0;
                    if (num_lines == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        // The first request leaves straight from the start cycle
                        if (!c0_tx_alm_full) begin
                            issue_c      = 1'b1;
                            issue_addr_c = base_addr;
                            issue_tag_c  = '0;
                            issued_d     = CNT_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!c0_tx_alm_full && (outst_q < OUT_W'(MAX_OUTSTANDING)) && (issued_q < num_q)) begin
                    issue_c  = 1'b1;
                    issued_d = issued_q + CNT_W'(1);
                end
                if (issued_d == num_q) begin
                    state_d = (rcvd_d == num_q) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rcvd_d == num_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        outst_d = outst_q + OUT_W'(issue_c) - OUT_W'(rsp_acc_c);

`ifdef CCIP_RD_TIMEOUT_EN
        to_cnt_d = (rsp_acc_c || (outst_q == '0)) ? '0 : to_cnt_q + TO_W'(1);
        err_d    = err_q;
        to_hit_c = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && (outst_q != '0) &&
                   !rsp_acc_c && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        // Watchdog abandons the in-flight requests so the counter stops
        if (to_hit_c) begin
            state_d  = S_DONE;
            issue_c  = 1'b0;
            issued_d = issued_q;
            outst_d  = '0;
            to_cnt_d = '0;
            err_d    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            outst_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            txv_q    <= 1'b0;
            txa_q    <= '0;
            txm_q    <= '0;
            ov_q     <= 1'b0;
            oidx_q   <= '0;
            odata_q  <= '0;
`ifdef CCIP_RD_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            rcvd_q   <= rcvd_d;
            outst_q  <= outst_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_q == S_DONE);
            txv_q    <= issue_c;
            if (issue_c) begin
                txa_q <= issue_addr_c;
                txm_q <= TAG_W'(issue_tag_c);
            end
            ov_q <= rsp_acc_c;
            if (rsp_acc_c) begin
                oidx_q  <= CNT_W'(rx_c0_mdata);
                odata_q <= rx_c0_data;
            end
`ifdef CCIP_RD_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign tx_c0_valid = txv_q;
    assign tx_c0_addr  = txa_q;
    assign tx_c0_mdata = txm_q;
    assign out_valid   = ov_q;
    assign out_idx     = oidx_q;
    assign out_data    = odata_q;
`ifdef CCIP_RD_TIMEOUT_EN
    assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_ccip_rd_requester.sv
// Directed self-checking bench for ccip_rd_requester; outputs sampled on the falling clock edge.

module tb_ccip_rd_requester;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [41:0]  base_addr;
    logic [15:0]  num_lines;
    logic         busy, done, tx_c0_valid;
    logic [41:0]  tx_c0_addr;
    logic [15:0]  tx_c0_mdata;
    logic         c0_tx_alm_full;
    logic         rx_c0_rsp_valid;
    logic [15:0]  rx_c0_mdata;
    logic [511:0] rx_c0_data;
    logic         out_valid;
    logic [15:0]  out_idx;
    logic [511:0] out_data;
`ifdef CCIP_RD_TIMEOUT_EN
    logic         timeout_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [41:0]  req_addr_q[$];
    logic [15:0]  req_tag_q[$];
    logic [15:0]  out_idx_q[$];
    logic [511:0] out_data_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ccip_rd_requester #(
        .MAX_OUTSTANDING(16),
        .CNT_W(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .num_lines(num_lines),
        .busy(busy),
        .done(done),
        .tx_c0_valid(tx_c0_valid),
        .tx_c0_addr(tx_c0_addr),
        .tx_c0_mdata(tx_c0_mdata),
        .c0_tx_alm_full(c0_tx_alm_full),
        .rx_c0_rsp_valid(rx_c0_rsp_valid),
        .rx_c0_mdata(rx_c0_mdata),
        .rx_c0_data(rx_c0_data),
        .out_valid(out_valid),
        .out_idx(out_idx),
        .out_data(out_data)
`ifdef CCIP_RD_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    // Passive record of requests, returned lines and done pulses
    always @(negedge clk) begin
        if (tx_c0_valid) begin
            req_addr_q.push_back(tx_c0_addr);
            req_tag_q.push_back(tx_c0_mdata);
        end
        if (out_valid) begin
            out_idx_q.push_back(out_idx);
            out_data_q.push_back(out_data);
        end
        if (done) done_cnt++;
    end

    function automatic logic [511:0] mk_data(input logic [15:0] tag);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = {16'hA5A5 ^ 16'(i), tag};
        return d;
    endfunction

    task automatic clear_mon();
        req_addr_q.delete();
        req_tag_q.delete();
        out_idx_q.delete();
        out_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [41:0] b, input logic [15:0] n);
        @(negedge clk);
        base_addr = b;
        num_lines = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_rsp(input logic [15:0] tag);
        rx_c0_rsp_valid = 1'b1;
        rx_c0_mdata     = tag;
        rx_c0_data      = mk_data(tag);
        @(negedge clk);
        rx_c0_rsp_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, output bit ok);
        int i;
        i = 0;
        #1;
        while (req_addr_q.size() < n && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        ok = (req_addr_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (tx_c0_valid !== 1'b0) begin n_err++; $display("FAIL reset_txv: got %b want 0", tx_c0_valid); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_outv: got %b want 0", out_valid); end
        n_vec++; if (tx_c0_addr !== 42'h0 || tx_c0_mdata !== 16'h0) begin
            n_err++; $display("FAIL reset_tx_fields: addr %h mdata %h want 0/0", tx_c0_addr, tx_c0_mdata); end
        n_vec++; if (out_idx !== 16'h0 || out_data !== 512'h0) begin
            n_err++; $display("FAIL reset_out_fields: idx %h data %h want 0/0", out_idx, out_data); end
`ifdef CCIP_RD_TIMEOUT_EN
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || tx_c0_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: busy %b txv %b want 0/0", busy, tx_c0_valid); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        do_start(42'h1000, 16'd4);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_vec++; if (tx_c0_valid !== 1'b1 || tx_c0_addr !== 42'h1000) begin
            n_err++; $display("FAIL basic_first_req: valid %b addr %h want 1/1000", tx_c0_valid, tx_c0_addr); end
        wait_reqs(4, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_req_wait: saw %0d requests want 4", req_addr_q.size()); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) send_rsp(16'(i));
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 16'd3) begin
            n_err++; $display("FAIL basic_rsp_latency: outv %b idx %0d want 1/3", out_valid, out_idx); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_done: done %b busy %b want 1/0", done, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        #1;
        n_vec++; if (req_addr_q.size() != 4 || out_idx_q.size() != 4 || done_cnt != 1) begin
            n_err++; $display("FAIL basic_counts: reqs %0d outs %0d dones %0d want 4/4/1",
                              req_addr_q.size(), out_idx_q.size(), done_cnt); end
        for (int i = 0; i < 4 && i < req_addr_q.size() && i < out_idx_q.size(); i++) begin
            n_vec++; if (req_addr_q[i] !== 42'h1000 + 42'(i) || req_tag_q[i] !== 16'(i)) begin
                n_err++; $display("FAIL basic_req%0d: addr %h tag %0d want %h/%0d", i, req_addr_q[i], req_tag_q[i],
                                  42'h1000 + 42'(i), i); end
            n_vec++; if (out_idx_q[i] !== 16'(i) || out_data_q[i] !== mk_data(16'(i))) begin
                n_err++; $display("FAIL basic_out%0d: idx %0d data %h want %0d", i, out_idx_q[i], out_data_q[i], i); end
        end
    endtask

    task automatic test_outstanding_limit();
        clear_mon();
        do_start(42'h2000, 16'd40);
        repeat (30) @(negedge clk);
        #1;
        n_vec++; if (req_addr_q.size() != 16 || tx_c0_valid !== 1'b0) begin
            n_err++; $display("FAIL limit_stall: reqs %0d txv %b want 16/0", req_addr_q.size(), tx_c0_valid); end
        send_rsp(16'd0);
        repeat (5) @(negedge clk);
        #1;
        n_vec++; if (req_addr_q.size() != 17) begin
            n_err++; $display("FAIL limit_one_more: reqs %0d want 17", req_addr_q.size()); end
        else begin
            n_vec++; if (req_addr_q[16] !== 42'h2010) begin
                n_err++; $display("FAIL limit_next_addr: got %h want 2010", req_addr_q[16]); end
        end
        for (int i = 1; i < 40; i++) send_rsp(16'(i));
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL limit_done: done %b busy %b want 1/0", done, busy); end
        #1;
        n_vec++; if (req_addr_q.size() != 40 || out_idx_q.size() != 40) begin
            n_err++; $display("FAIL limit_counts: reqs %0d outs %0d want 40/40", req_addr_q.size(), out_idx_q.size()); end
        for (int i = 0; i < 40 && i < req_addr_q.size(); i++) begin
            n_vec++; if (req_addr_q[i] !== 42'h2000 + 42'(i) || req_tag_q[i] !== 16'(i)) begin
                n_err++; $display("FAIL limit_req%0d: addr %h tag %0d", i, req_addr_q[i], req_tag_q[i]); end
        end
    endtask

    task automatic test_alm_full();
        bit ok;
        clear_mon();
        do_start(42'h3000, 16'd12);
        repeat (2) @(negedge clk);
        c0_tx_alm_full = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_vec++; if (tx_c0_valid !== 1'b0) begin
                n_err++; $display("FAIL almfull_gate_c%0d: txv %b want 0", j, tx_c0_valid); end
        end
        c0_tx_alm_full = 1'b0;
        wait_reqs(12, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL almfull_resume: reqs %0d want 12", req_addr_q.size()); end
        for (int i = 0; i < 12; i++) send_rsp(16'(i));
        @(negedge clk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL almfull_done: got %b want 1", done); end
        #1;
        n_vec++; if (req_addr_q.size() != 12) begin
            n_err++; $display("FAIL almfull_count: reqs %0d want 12", req_addr_q.size()); end
        for (int i = 0; i < 12 && i < req_addr_q.size(); i++) begin
            n_vec++; if (req_addr_q[i] !== 42'h3000 + 42'(i) || req_tag_q[i] !== 16'(i)) begin
                n_err++; $display("FAIL almfull_req%0d: addr %h tag %0d", i, req_addr_q[i], req_tag_q[i]); end
        end
    endtask

    task automatic test_out_of_order();
        bit ok;
        logic [15:0] ord [4];
        ord = '{16'd3, 16'd0, 16'd2, 16'd1};
        clear_mon();
        do_start(42'h4000, 16'd4);
        wait_reqs(4, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL ooo_req_wait: reqs %0d want 4", req_addr_q.size()); end
        for (int i = 0; i < 4; i++) send_rsp(ord[i]);
        #1;
        n_vec++; if (done_cnt != 0 || busy !== 1'b1) begin
            n_err++; $display("FAIL ooo_early_done: dones %0d busy %b want 0/1", done_cnt, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL ooo_done: done %b busy %b want 1/0", done, busy); end
        #1;
        n_vec++; if (out_idx_q.size() != 4) begin n_err++; $display("FAIL ooo_count: outs %0d want 4", out_idx_q.size()); end
        for (int i = 0; i < 4 && i < out_idx_q.size(); i++) begin
            n_vec++; if (out_idx_q[i] !== ord[i] || out_data_q[i] !== mk_data(ord[i])) begin
                n_err++; $display("FAIL ooo_out%0d: idx %0d want %0d", i, out_idx_q[i], ord[i]); end
        end
    endtask

    task automatic test_zero_lines();
        clear_mon();
        do_start(42'h7000, 16'd0);
        n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL zero_t1: busy %b done %b want 1/0", busy, done); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL zero_t2: done %b busy %b want 1/0", done, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_pulse: done %b want 0", done); end
        #1;
        n_vec++; if (req_addr_q.size() != 0) begin n_err++; $display("FAIL zero_noreq: reqs %0d want 0", req_addr_q.size()); end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_mon();
        do_start(42'h5000, 16'd3);
        @(negedge clk);
        base_addr = 42'h9000;
        num_lines = 16'd5;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        wait_reqs(3, ok);
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (!ok || req_addr_q.size() != 3) begin
            n_err++; $display("FAIL busystart_reqs: reqs %0d want 3", req_addr_q.size()); end
        for (int i = 0; i < 3; i++) send_rsp(16'(i));
        @(negedge clk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL busystart_done: got %b want 1", done); end
        repeat (4) @(negedge clk);
        #1;
        n_vec++; if (req_addr_q.size() != 3 || done_cnt != 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL busystart_after: reqs %0d dones %0d busy %b want 3/1/0",
                              req_addr_q.size(), done_cnt, busy); end
        for (int i = 0; i < 3 && i < req_addr_q.size(); i++) begin
            n_vec++; if (req_addr_q[i] !== 42'h5000 + 42'(i)) begin
                n_err++; $display("FAIL busystart_addr%0d: got %h want %h", i, req_addr_q[i], 42'h5000 + 42'(i)); end
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        clear_mon();
        do_start(42'h3FF_FFFF_FFFF, 16'd2);
        wait_reqs(2, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_wait: reqs %0d want 2", req_addr_q.size()); end
        else begin
            n_vec++; if (req_addr_q[0] !== 42'h3FF_FFFF_FFFF || req_tag_q[0] !== 16'd0) begin
                n_err++; $display("FAIL wrap_req0: addr %h tag %0d want 3ffffffffff/0", req_addr_q[0], req_tag_q[0]); end
            n_vec++; if (req_addr_q[1] !== 42'h0 || req_tag_q[1] !== 16'd1) begin
                n_err++; $display("FAIL wrap_req1: addr %h tag %0d want 0/1", req_addr_q[1], req_tag_q[1]); end
        end
        send_rsp(16'd0);
        send_rsp(16'd1);
        @(negedge clk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b want 1", done); end
    endtask

    task automatic test_reset_midop();
        bit ok;
        clear_mon();
        do_start(42'h8000, 16'd4);
        wait_reqs(4, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0 || tx_c0_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: busy %b txv %b want 0/0", busy, tx_c0_valid); end
        send_rsp(16'd0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale_rsp: outv %b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_nodone: done %b want 0", done); end
        clear_mon();
        do_start(42'hA000, 16'd1);
        n_vec++; if (tx_c0_valid !== 1'b1 || tx_c0_addr !== 42'hA000 || tx_c0_mdata !== 16'd0) begin
            n_err++; $display("FAIL midrst_restart: txv %b addr %h tag %0d want 1/a000/0", tx_c0_valid, tx_c0_addr, tx_c0_mdata); end
        send_rsp(16'd0);
        n_vec++; if (out_valid !== 1'b1 || out_idx !== 16'd0) begin
            n_err++; $display("FAIL midrst_rsp: outv %b idx %0d want 1/0", out_valid, out_idx); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_done: done %b busy %b want 1/0", done, busy); end
    endtask

`ifdef CCIP_RD_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int t_rsp, t_done, i;
        clear_mon();
        do_start(42'h6000, 16'd2);
        wait_reqs(2, ok);
        t_rsp = cyc;
        send_rsp(16'd0);
        i = 0;
        while (done !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        t_done = cyc;
        n_vec++; if (done !== 1'b1 || timeout_err !== 1'b1) begin
            n_err++; $display("FAIL timeout_fire: done %b terr %b want 1/1", done, timeout_err); end
        n_vec++; if (t_done - t_rsp < 100 || t_done - t_rsp > 104) begin
            n_err++; $display("FAIL timeout_delay: %0d cycles want 100..104", t_done - t_rsp); end
        repeat (3) @(negedge clk);
        n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        base_addr       = '0;
        num_lines       = '0;
        c0_tx_alm_full  = 1'b0;
        rx_c0_rsp_valid = 1'b0;
        rx_c0_mdata     = '0;
        rx_c0_data      = '0;
        test_reset();
        test_basic();
        test_outstanding_limit();
        test_alm_full();
        test_out_of_order();
        test_zero_lines();
        test_start_while_busy();
        test_addr_wrap();
        test_reset_midop();
`ifdef CCIP_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
